// File: rtl/invader_pkg.sv
// Shared types and constants for the invader formation blocks.
// MULTIPLIER is the sub-pixel scale used by the position integrator.
// speed_t is the per-frame speed word exchanged with that integrator.
package invader_pkg;

  localparam int MULTIPLIER = 64;

  // Signed 11-bit speed in 1/MULTIPLIER px per frame.
  typedef logic signed [10:0] speed_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_MARCH_R = 3'd1,
    ST_DROP_L  = 3'd2,
    ST_MARCH_L = 3'd3,
    ST_DROP_R  = 3'd4,
    ST_FREEZE  = 3'd5
  } march_state_t;

  // True while the formation is marching horizontally.
  function automatic logic isMarch(input march_state_t s);
    return (s == ST_MARCH_R) || (s == ST_MARCH_L);
  endfunction

  // True while the formation is stepping down a row.
  function automatic logic isDrop(input march_state_t s);
    return (s == ST_DROP_L) || (s == ST_DROP_R);
  endfunction

endpackage

// File: rtl/frame_tick_div.sv
// Frame divider: counts startOfFrame pulses and produces a one-second tick.
// wrapNow is high combinationally during the startOfFrame cycle in which the
// count sits at FRAMES_PER_SEC-1, so other logic can act on that same edge.
// oneSec is the registered version: high for the one clk after that edge.
module frame_tick_div #(
  parameter int FRAMES_PER_SEC = 30
) (
  input  logic clk,
  input  logic reset,
  input  logic startOfFrame,
  output logic wrapNow,
  output logic oneSec
);

  localparam int CW = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
  localparam logic [CW-1:0] LAST = CW'(FRAMES_PER_SEC - 1);

  logic [CW-1:0] frameCnt;

  assign wrapNow = startOfFrame && (frameCnt == LAST);

  // Frame counter: advances on each frame pulse, wraps at FRAMES_PER_SEC-1.
  always_ff @(posedge clk) begin
    if (reset) begin
      frameCnt <= '0;
    end else if (startOfFrame) begin
      if (frameCnt == LAST) frameCnt <= '0;
      else                  frameCnt <= frameCnt + 1'b1;
    end
  end

  // One-clk tick following the wrapping frame edge.
  always_ff @(posedge clk) begin
    if (reset) oneSec <= 1'b0;
    else       oneSec <= wrapNow;
  end

endmodule

// File: rtl/invader_march_ctrl.sv
// Invader formation march sequencer.
// Decides per frame whether the formation marches right/left, drops a row,
// freezes after a player hit, or idles, and produces the per-frame speed
// consumed by the position integrator on the following frame.
// Optional feature: define INVADER_TIME_ACCEL_EN to add one speed unit per
// second spent marching (saturating, cleared on entry to IDLE).
// stateDbg exposes the current FSM state for observation.
module invader_march_ctrl
  import invader_pkg::*;
#(
  parameter int FRAMES_PER_SEC = 30,
  parameter int DROP_FRAMES    = 8,
  parameter int FREEZE_FRAMES  = 60,
  parameter int BASE_SPEED     = 60,
  parameter int KILL_STEP      = 4,
  parameter int MAX_SPEED      = 400,
  parameter int Y_SPEED        = 64,
  parameter int TOTAL_INVADERS = 40
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         startOfFrame,
  input  logic         gameRun,
  input  logic         leftEdge,
  input  logic         rightEdge,
  input  logic         playerHit,
  input  logic [5:0]   aliveCount,
  output speed_t       xSpeed,
  output logic [10:0]  ySpeed,
  output logic         dirRight,
  output logic         frozen,
  output logic         oneSec,
  output march_state_t stateDbg
);

  localparam int PHASE_MAX = (DROP_FRAMES > FREEZE_FRAMES) ? DROP_FRAMES : FREEZE_FRAMES;
  localparam int PW        = $clog2(PHASE_MAX + 1);
  localparam logic [PW-1:0] DROP_LAST   = PW'(DROP_FRAMES - 1);
  localparam logic [PW-1:0] FREEZE_LAST = PW'(FREEZE_FRAMES - 1);

  march_state_t state, nextState;
  logic [PW-1:0] phaseCnt;
  logic          hitFlag;
  logic          hitEff;
  logic          tickNow;
  logic [10:0]   spdReg;
  logic [11:0]   timeBonus;
  logic [11:0]   alive12;
  logic [11:0]   killed;
  logic [11:0]   spdSum;
  logic [10:0]   spdClamped;

  // A hit arriving in the same cycle as the frame pulse still counts.
  assign hitEff   = hitFlag | playerHit;
  assign stateDbg = state;

  frame_tick_div #(
    .FRAMES_PER_SEC(FRAMES_PER_SEC)
  ) uTick (
    .clk         (clk),
    .reset       (reset),
    .startOfFrame(startOfFrame),
    .wrapNow     (tickNow),
    .oneSec      (oneSec)
  );

  // Next-state selection in priority order: stop, wipe-out, hit, edges/counters.
  always_comb begin
    nextState = state;
    if (!gameRun) begin
      nextState = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: nextState = ST_MARCH_R;
        ST_MARCH_R: begin
          if (aliveCount == 6'd0) nextState = ST_IDLE;
          else if (hitEff)        nextState = ST_FREEZE;
          else if (rightEdge)     nextState = ST_DROP_L;
        end
        ST_MARCH_L: begin
          if (aliveCount == 6'd0) nextState = ST_IDLE;
          else if (hitEff)        nextState = ST_FREEZE;
          else if (leftEdge)      nextState = ST_DROP_R;
        end
        ST_DROP_L: begin
          if (hitEff)                     nextState = ST_FREEZE;
          else if (phaseCnt == DROP_LAST) nextState = ST_MARCH_L;
        end
        ST_DROP_R: begin
          if (hitEff)                     nextState = ST_FREEZE;
          else if (phaseCnt == DROP_LAST) nextState = ST_MARCH_R;
        end
        ST_FREEZE: begin
          if (phaseCnt == FREEZE_LAST) nextState = dirRight ? ST_MARCH_R : ST_MARCH_L;
        end
        default: nextState = ST_IDLE;
      endcase
    end
  end

  // State register, advanced only on frame pulses.
  always_ff @(posedge clk) begin
    if (reset)             state <= ST_IDLE;
    else if (startOfFrame) state <= nextState;
  end

  // Drop/freeze dwell counter: zeroed on any state change, counts frames inside.
  always_ff @(posedge clk) begin
    if (reset) begin
      phaseCnt <= '0;
    end else if (startOfFrame) begin
      if (nextState != state)                       phaseCnt <= '0;
      else if (isDrop(state) || state == ST_FREEZE) phaseCnt <= phaseCnt + 1'b1;
    end
  end

  // Sticky hit flag: cleared on entering FREEZE, ignored while frozen.
  always_ff @(posedge clk) begin
    if (reset) begin
      hitFlag <= 1'b0;
    end else if (startOfFrame) begin
      if (state == ST_FREEZE || nextState == ST_FREEZE) hitFlag <= 1'b0;
      else                                              hitFlag <= hitEff;
    end else if (playerHit && state != ST_FREEZE) begin
      hitFlag <= 1'b1;
    end
  end

  // Resumption direction: follows whichever march state is being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      dirRight <= 1'b1;
    end else if (startOfFrame) begin
      if (nextState == ST_MARCH_R)      dirRight <= 1'b1;
      else if (nextState == ST_MARCH_L) dirRight <= 1'b0;
    end
  end

`ifdef INVADER_TIME_ACCEL_EN
  // Time bonus: +1 per second of marching, saturating, cleared entering IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      timeBonus <= '0;
    end else if (startOfFrame) begin
      if (nextState == ST_IDLE)
        timeBonus <= '0;
      else if (tickNow && isMarch(state) && timeBonus < 12'(MAX_SPEED))
        timeBonus <= timeBonus + 12'd1;
    end
  end
`else
  logic unusedTick;
  assign unusedTick = tickNow;
  assign timeBonus  = '0;
`endif

  // Speed arithmetic in 12 bits; aliveCount above the formation size means no kills.
  always_comb begin
    alive12 = {6'd0, aliveCount};
    killed  = '0;
    if (alive12 <= 12'(TOTAL_INVADERS)) killed = 12'(TOTAL_INVADERS) - alive12;
    spdSum     = 12'(BASE_SPEED) + killed * 12'(KILL_STEP) + timeBonus;
    spdClamped = spdSum[10:0];
    if (spdSum > 12'(MAX_SPEED)) spdClamped = 11'(MAX_SPEED);
  end

  // Speed register, refreshed every frame pulse.
  always_ff @(posedge clk) begin
    if (reset)             spdReg <= '0;
    else if (startOfFrame) spdReg <= spdClamped;
  end

  // Output decode from registered state and speed.
  always_comb begin
    xSpeed = '0;
    ySpeed = '0;
    frozen = (state == ST_FREEZE);
    case (state)
      ST_MARCH_R: xSpeed = speed_t'(spdReg);
      ST_MARCH_L: xSpeed = -speed_t'(spdReg);
      ST_DROP_L,
      ST_DROP_R:  ySpeed = 11'(Y_SPEED);
      default:    xSpeed = '0;
    endcase
  end

endmodule

// File: tb/tb_invader_march_ctrl.sv
// Testbench for invader_march_ctrl: directed test-plan steps followed by a
// randomized run, all checked against a frame-level reference model.
module tb_invader_march_ctrl;
  import invader_pkg::*;

  localparam int FPS        = 30;
  localparam int DROP_N     = 8;
  localparam int FREEZE_N   = 60;
  localparam int BASE       = 60;
  localparam int KSTEP      = 4;
  localparam int MAXS       = 400;
  localparam int YS         = 64;
  localparam int TOTAL      = 40;

  logic         clk = 1'b0;
  logic         reset;
  logic         startOfFrame;
  logic         gameRun;
  logic         leftEdge;
  logic         rightEdge;
  logic         playerHit;
  logic [5:0]   aliveCount;
  speed_t       xSpeed;
  logic [10:0]  ySpeed;
  logic         dirRight;
  logic         frozen;
  logic         oneSec;
  march_state_t stateDbg;

  int total = 0;
  int bad   = 0;

  // Reference model: mode names, speed, bonus, frame phase, time in mode.
  string mMode;
  int    mSpd, mBonus, mFrame, mElapsed;
  bit    mHit, mDir, mTick;

  invader_march_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .startOfFrame(startOfFrame),
    .gameRun     (gameRun),
    .leftEdge    (leftEdge),
    .rightEdge   (rightEdge),
    .playerHit   (playerHit),
    .aliveCount  (aliveCount),
    .xSpeed      (xSpeed),
    .ySpeed      (ySpeed),
    .dirRight    (dirRight),
    .frozen      (frozen),
    .oneSec      (oneSec),
    .stateDbg    (stateDbg)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int speedFor(input int alive, input int bonus);
    int killed, s;
    killed = (alive > TOTAL) ? 0 : TOTAL - alive;
    s = BASE + killed * KSTEP + bonus;
    return (s > MAXS) ? MAXS : s;
  endfunction

  task automatic modelReset();
    mMode = "idle"; mSpd = 0; mBonus = 0; mFrame = 0; mElapsed = 0;
    mHit = 0; mDir = 1; mTick = 0;
  endtask

  // Applies the frame rules to the inputs present at a frame edge.
  task automatic modelSof();
    bit    hitEff, wrap, inMarch, inDrop;
    string nxt;
    hitEff  = mHit | playerHit;
    wrap    = (mFrame == FPS - 1);
    inMarch = (mMode == "march_r") || (mMode == "march_l");
    inDrop  = (mMode == "drop_l") || (mMode == "drop_r");
    nxt     = mMode;
    if (!gameRun)                                  nxt = "idle";
    else if (inMarch && aliveCount == 0)           nxt = "idle";
    else if ((inMarch || inDrop) && hitEff)        nxt = "freeze";
    else if (mMode == "idle")                      nxt = "march_r";
    else if (mMode == "march_r" && rightEdge)      nxt = "drop_l";
    else if (mMode == "march_l" && leftEdge)       nxt = "drop_r";
    else if (inDrop && mElapsed + 1 == DROP_N) begin
      if (mMode == "drop_l") nxt = "march_l";
      else                   nxt = "march_r";
    end else if (mMode == "freeze" && mElapsed + 1 == FREEZE_N) begin
      if (mDir) nxt = "march_r";
      else      nxt = "march_l";
    end
    mSpd = speedFor(int'(aliveCount), mBonus);
`ifdef INVADER_TIME_ACCEL_EN
    if (nxt == "idle")                          mBonus = 0;
    else if (wrap && inMarch && mBonus < MAXS)  mBonus = mBonus + 1;
`endif
    mHit     = (mMode == "freeze" || nxt == "freeze") ? 1'b0 : hitEff;
    mElapsed = (nxt == mMode) ? mElapsed + 1 : 0;
    if (nxt == "march_r") mDir = 1;
    if (nxt == "march_l") mDir = 0;
    mFrame = (mFrame + 1) % FPS;
    mTick  = wrap;
    mMode  = nxt;
  endtask

  // Between frame pulses only the hit flag can change.
  task automatic modelQuiet();
    if (playerHit && mMode != "freeze") mHit = 1;
    mTick = 0;
  endtask

  task automatic checkOut(input string tag);
    int ex, ey;
    ex = 0; ey = 0;
    if (mMode == "march_r") ex = mSpd;
    if (mMode == "march_l") ex = -mSpd;
    if (mMode == "drop_l" || mMode == "drop_r") ey = YS;
    chk({tag, ".xSpeed"},   int'(xSpeed),   ex);
    chk({tag, ".ySpeed"},   int'(ySpeed),   ey);
    chk({tag, ".dirRight"}, int'(dirRight), int'(mDir));
    chk({tag, ".frozen"},   int'(frozen),   (mMode == "freeze") ? 1 : 0);
    chk({tag, ".oneSec"},   int'(oneSec),   int'(mTick));
  endtask

  // Reset driver
  task automatic doReset();
    reset = 1'b1;
    @(posedge clk);
    modelReset();
    #1 reset = 1'b0;
    checkOut("reset");
  endtask

  // One frame of three clocks: pulse, quiet, quiet (optional mid-frame hit).
  task automatic doFrame(input bit hitAtSof, input bit hitMid);
    startOfFrame = 1'b1;
    playerHit    = hitAtSof;
    @(posedge clk);
    modelSof();
    #1 startOfFrame = 1'b0;
    playerHit = 1'b0;
    checkOut("frame");
    @(posedge clk);
    modelQuiet();
    #1 chk("oneSec_low", int'(oneSec), 0);
    playerHit = hitMid;
    @(posedge clk);
    modelQuiet();
    #1 playerHit = 1'b0;
  endtask

  task automatic runFrames(input int n);
    for (int i = 0; i < n; i++) doFrame(1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; startOfFrame = 1'b0; gameRun = 1'b0;
    leftEdge = 1'b0; rightEdge = 1'b0; playerHit = 1'b0; aliveCount = 6'd40;
    modelReset();
    @(negedge clk);
    doReset();
    chk("reset_dir", int'(dirRight), 1);

    // Start marching right at full formation.
    gameRun = 1'b1;
    doFrame(1'b0, 1'b0);
    chk("start_x", int'(xSpeed), BASE);
    runFrames(150);
`ifdef INVADER_TIME_ACCEL_EN
    chk("five_sec_x", int'(xSpeed), 65);
`else
    chk("five_sec_x", int'(xSpeed), 60);
`endif

    // Right edge: drop for DROP_N frames, then march left.
    rightEdge = 1'b1;
    doFrame(1'b0, 1'b0);
    rightEdge = 1'b0;
    chk("drop_y", int'(ySpeed), YS);
    runFrames(DROP_N - 1);
    chk("still_drop", int'(ySpeed), YS);
    doFrame(1'b0, 1'b0);
    chk("left_dir", int'(dirRight), 0);

    // Kills speed the march up.
    aliveCount = 6'd30;
    runFrames(2);

    // Hit in the middle of a drop: freeze, then resume leftward.
    leftEdge = 1'b1;
    doFrame(1'b0, 1'b0);
    leftEdge = 1'b0;
    runFrames(2);
    doFrame(1'b0, 1'b1);
    doFrame(1'b0, 1'b0);
    chk("freeze_on", int'(frozen), 1);
    doFrame(1'b0, 1'b1);
    runFrames(FREEZE_N - 2);
    chk("freeze_hold", int'(frozen), 1);
    doFrame(1'b0, 1'b0);
    chk("freeze_off", int'(frozen), 0);
    runFrames(2);

    // Formation wiped out while marching left.
    aliveCount = 6'd0;
    doFrame(1'b0, 1'b0);
    chk("wipe_x", int'(xSpeed), 0);
    aliveCount = 6'd40;
    runFrames(3);

    // Stop wins over edge and hit at the same frame.
    gameRun = 1'b0; rightEdge = 1'b1;
    doFrame(1'b1, 1'b0);
    chk("stop_x", int'(xSpeed), 0);
    chk("stop_y", int'(ySpeed), 0);
    gameRun = 1'b1; rightEdge = 1'b0;
    runFrames(4);

    // Reset in the middle of play.
    aliveCount = 6'd50;
    runFrames(3);
    @(negedge clk);
    doReset();

    // Randomized play.
    for (int i = 0; i < 500; i++) begin
      gameRun    = ($urandom_range(0, 24) != 0);
      leftEdge   = ($urandom_range(0, 5) == 0);
      rightEdge  = ($urandom_range(0, 5) == 0);
      aliveCount = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63))
                                               : 6'($urandom_range(1, 40));
      doFrame(($urandom_range(0, 29) == 0), ($urandom_range(0, 29) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
